// File: rtl/signed_fubar2_accum_if.sv
// rtl/signed_fubar2_accum_if.sv - sample-in / block-sum-out handshake bundle
// master drives samples and out_ready; slave is the accumulator.
interface signed_fubar2_accum_if #(
  parameter int ACC_W = 8
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/signed_fubar2_accum.sv
// rtl/signed_fubar2_accum.sv - sums blocks of NSAMP 2-bit signed samples into ACC_W-bit results
// Define SIGNED_FUBAR2_ACCUM_SAT_EN to saturate instead of wrapping on overflow.
module signed_fubar2_accum #(
  parameter int ACC_W = 8,
  parameter int NSAMP = 4
) (
  input logic                  clk,
  input logic                  rst,
  signed_fubar2_accum_if.slave bus
);
  localparam int CW = $clog2(NSAMP) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSAMP - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             ovf_q, ovf_d;
  logic             out_ovf_q, out_ovf_d;
  logic             run_q, run_d;

  logic [ACC_W-1:0] sext, base, sum, acc_new;
  logic             step_ovf, ovf_new, in_ready, accept;

  always_comb begin
    sext     = {{(ACC_W-2){bus.in_data[1]}}, bus.in_data};
    base     = (count_q == '0) ? '0 : acc_q;
    sum      = base + sext;
    step_ovf = (base[ACC_W-1] == sext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
`ifdef SIGNED_FUBAR2_ACCUM_SAT_EN
    // On overflow both addends share a sign, so the sample's sign picks the rail.
    acc_new  = step_ovf ? (sext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}}) : sum;
`else
    acc_new  = sum;
`endif
    ovf_new  = ((count_q == '0) ? 1'b0 : ovf_q) | step_ovf;
  end

  // run_q keeps in_ready low until the first clock after reset release.
  assign run_d    = 1'b1;
  assign in_ready = run_q && ((state_q != HOLD) || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    if (bus.clr) begin
      state_d = IDLE;
      count_d = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      if (count_q == LAST_CNT) begin
        out_sum_d = acc_new;
        out_ovf_d = ovf_new;
        count_d   = '0;
        state_d   = HOLD;
      end else begin
        acc_d   = acc_new;
        ovf_d   = ovf_new;
        count_d = count_q + CW'(1);
        state_d = ACCUM;
      end
    end else if ((state_q == HOLD) && bus.out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
      run_q     <= run_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: doc/signed_fubar2_accum.md
Name: signed_fubar2_accum

Overview:
- Downstream consumer of the 2-bit signed sample stream produced by autoinst_signed_fubar2 on its another_output2[1:0] output.
- Accepts samples over a valid/ready handshake and sign-extends each one.
- Sums blocks of NSAMP samples and presents each block sum on a registered valid/ready output.
- Sits between the fubar2 wrapper and any wider-datapath logic that needs aggregated signed values.

Parameters:
- ACC_W, 8: accumulator and output width in bits, two's complement, minimum 3.
- NSAMP, 4: samples per block, minimum 1; internal count width is $clog2(NSAMP)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous flush: aborts the partial block and drops any pending output.
- in_valid  input  1  a sample is present on in_data.
- in_ready  output  1  the block can accept a sample this cycle.
- in_data  input  2  signed sample from another_output2[1:0], range -2..1.
- out_valid  output  1  out_sum and out_ovf are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_sum  output  ACC_W  signed block sum.
- out_ovf  output  1  an intermediate overflow occurred in this block.

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=IDLE, count=0, acc=0.
  - out_valid=0, out_sum=0, out_ovf=0, in_ready=0 (in_ready rises in the first cycle after rst deasserts).
- Handshakes:
  - Input transfer occurs when in_valid&in_ready.
  - Output transfer occurs when out_valid&out_ready.
  - out_sum and out_ovf are registered and held stable while out_valid=1 and out_ready=0.
- Arithmetic:
  - Each sample is sign-extended to ACC_W.
  - acc_next = (count==0 ? 0 : acc) + sext(in_data).
  - Overflow means both addend signs are equal and the result sign differs; it is ORed into a per-block ovf bit.
  - The default wraps modulo 2^ACC_W.
- States:
  - IDLE (count=0, in_ready=1): an accepted sample moves to ACCUM with count=1. If NSAMP=1, it moves straight to HOLD instead.
  - ACCUM (in_ready=1): each accept increments count. The accept that makes count==NSAMP loads out_sum/out_ovf, sets out_valid, clears count, and moves to HOLD.
  - HOLD (out_valid=1, in_ready=out_ready):
    - out_ready=0: stall.
    - out_ready=1, in_valid=0: out_valid drops next cycle and the state returns to IDLE.
    - out_ready=1, in_valid=1: the output transfers and the new sample starts the next block in the same cycle, so there is no bubble. With NSAMP=1, out_valid stays 1 with the new sum.
- Latency:
  - out_valid rises on the cycle after the NSAMP-th accept.
  - Sustained throughput is one sample per cycle with out_ready held at 1.
- clr:
  - Highest priority after rst.
  - Next state is IDLE with count=0, ovf=0, out_valid=0; an in_valid sample in the same cycle is discarded.
  - in_ready stays 1 during clr except in HOLD, where it follows out_ready.
  - Any sample the upstream sees accepted during clr is dropped.
- in_data is ignored whenever in_valid=0.

Optional Feature:
- Macro: SIGNED_FUBAR2_ACCUM_SAT_EN.
- Defined: on overflow, acc saturates to 2^(ACC_W-1)-1 (positive) or -2^(ACC_W-1) (negative) and later samples add to the saturated value. out_ovf still reports the event.
- Undefined: wrap-around arithmetic as in Behaviour; out_ovf reports the wrap.

Test Plan:
- ACC_W=8, NSAMP=4, out_ready=1: inputs 1,1,-2,1 on consecutive cycles -> one cycle later out_valid=1, out_sum=8'h01, out_ovf=0; throughput of one sample per cycle across 3 back-to-back blocks.
- Backpressure: out_ready=0 for 5 cycles after a block of -2,-2,-2,-2 -> out_sum=8'hF8 held constant and in_ready=0 throughout; release with in_valid=1 -> both transfers occur in the same cycle.
- ACC_W=3, NSAMP=4, inputs -2,-2,-2,-2 -> macro undefined: out_sum=3'b000, out_ovf=1; macro defined: out_sum=3'b100, out_ovf=1.
- NSAMP=1, out_ready=1, inputs 1,-1,-2 -> out_sum sequence 8'h01, 8'hFF, 8'hFE with out_valid continuously high.
- clr after 2 of 4 samples, then 1,1,1,1 -> out_sum=8'h04; no residue from the aborted block.
- rst asserted asynchronously mid-block and mid-HOLD -> out_valid=0 and out_sum=0 immediately; the next full block sums correctly.
